// File: rtl/avr_data_arbiter.sv
// Shares the single-port data RAM between the AVR CPU data port (fixed priority) and a secondary master.
// Define AVR_ARB_STALL_EN to enable the starvation guard that stalls the CPU for one cycle.
module avr_data_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wen,
  input  logic              cpu_ren,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

`ifdef AVR_ARB_STALL_EN
  typedef enum logic [1:0] {IDLE, RD_DATA, STALL} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_DATA} state_t;
`endif

  state_t state;
  logic   cpu_own;
  logic   dma_own;
  logic   stall_now;

`ifdef AVR_ARB_STALL_EN
  assign stall_now = (state == STALL);
`else
  assign stall_now = 1'b0;
`endif

  // Grant is purely combinational and gated by reset so nothing reaches the RAM while held in reset.
  assign cpu_own = reset & (cpu_wen | cpu_ren) & ~stall_now;
  assign dma_own = reset & dma_req & ~cpu_own;

  assign mem_addr   = dma_own ? dma_addr  : cpu_addr;
  assign mem_wdata  = dma_own ? dma_wdata : cpu_wdata;
  assign mem_wen    = cpu_own ? cpu_wen : (dma_own & dma_we);
  assign mem_ren    = cpu_own ? cpu_ren : (dma_own & ~dma_we);
  assign dma_ack    = dma_own;
  assign cpu_stall  = stall_now;
  assign dma_rvalid = (state == RD_DATA);
  assign dma_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

`ifdef AVR_ARB_STALL_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  always_comb begin
    starve_nxt = '0;
    if (dma_req && !dma_own)
      starve_nxt = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Reaching the limit implies the DMA was denied, so STALL never collides with a pending read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (starve_nxt == CNT_W'(STARVE_LIMIT))
        state <= STALL;
      else if (dma_own && !dma_we)
        state <= RD_DATA;
      else
        state <= IDLE;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT > 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else if (dma_own && !dma_we)
      state <= RD_DATA;
    else
      state <= IDLE;
  end
`endif

endmodule

// File: tb/tb_avr_data_arbiter.sv
// Scoreboard bench for avr_data_arbiter: a shadow-memory model predicts grants and read data.
// Honours AVR_ARB_STALL_EN when the design is built with the starvation guard.
module tb_avr_data_arbiter;
  localparam int ADDR_W       = 16;
  localparam int STARVE_LIMIT = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wen;
  logic              cpu_ren;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [7:0]        dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              mem_ren;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       rdQ[$];
  exp_t       cpuQ[$];
  logic [7:0] ram[256];
  logic [7:0] shadow[256];
  int         checks;
  int         errors;
  int         posCount;
  int         starve;
  int         ackSeen;
  logic       modelAck;

  avr_data_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256x8 synchronous RAM with one-cycle read latency; upper address bits are ignored.
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, got, want);
    end
  endtask

  // Monitor: pops expected read data exactly when the DUT should present it.
  always begin : monitor
    exp_t e;
    logic expV;
    @(posedge clk);
    #1;
    posCount++;
    expV = (rdQ.size() > 0) && (rdQ[0].due == posCount);
    checkOutput("dma_rvalid", 16'(dma_rvalid), 16'(expV));
    if (expV) begin
      e = rdQ.pop_front();
      if (dma_rvalid) checkOutput("dma_rdata", 16'(dma_rdata), 16'(e.data));
    end
    if ((cpuQ.size() > 0) && (cpuQ[0].due == posCount)) begin
      e = cpuQ.pop_front();
      checkOutput("cpu_rdata", 16'(cpu_rdata), 16'(e.data));
    end
  end

  // One clock cycle of stimulus, entered and left on the falling edge.
  task automatic applyStimulus(input logic rst, input logic cWen, input logic cRen,
                               input logic [15:0] cAddr, input logic [7:0] cWd,
                               input logic dReq, input logic dWe,
                               input logic [15:0] dAddr, input logic [7:0] dWd,
                               input logic rstAfter);
    logic stallExp, cpuWins, dmaWins, expWen, expRen;
    logic [15:0] expAddr;
    reset = rst;  cpu_wen = cWen;  cpu_ren = cRen;  cpu_addr = cAddr;  cpu_wdata = cWd;
    dma_req = dReq;  dma_we = dWe;  dma_addr = dAddr;  dma_wdata = dWd;
    stallExp = 1'b0;
`ifdef AVR_ARB_STALL_EN
    stallExp = rst && (starve == STARVE_LIMIT);
`endif
    cpuWins = rst && (cWen || cRen) && !stallExp;
    dmaWins = rst && dReq && !cpuWins;
    expWen  = (cpuWins && cWen) || (dmaWins && dWe);
    expRen  = (cpuWins && cRen) || (dmaWins && !dWe);
    expAddr = dmaWins ? dAddr : cAddr;
    #1;
    if (dma_ack) ackSeen++;
    checkOutput("dma_ack", 16'(dma_ack), 16'(dmaWins));
    checkOutput("mem_wen", 16'(mem_wen), 16'(expWen));
    checkOutput("mem_ren", 16'(mem_ren), 16'(expRen));
    checkOutput("cpu_stall", 16'(cpu_stall), 16'(stallExp));
    checkOutput("mem_addr", mem_addr, expAddr);
    if (expWen) checkOutput("mem_wdata", 16'(mem_wdata), 16'(dmaWins ? dWd : cWd));
    @(posedge clk);
    if (rst) begin
      if (dmaWins && !dWe) rdQ.push_back('{data: shadow[dAddr[7:0]], due: posCount + 1});
      if (cpuWins && cRen) cpuQ.push_back('{data: shadow[cAddr[7:0]], due: posCount + 1});
      if (cpuWins && cWen) shadow[cAddr[7:0]] = cWd;
      if (dmaWins && dWe)  shadow[dAddr[7:0]] = dWd;
      if (dReq && !dmaWins) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else starve = 0;
    end else begin
      starve = 0;
    end
    modelAck = dmaWins;
    if (rstAfter) begin
      reset = 1'b0;
      rdQ.delete();
      cpuQ.delete();
      starve = 0;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0);
  endtask

  initial begin
    logic pending, pWe, cW, cR;
    logic [15:0] pAddr, cA;
    logic [7:0] pWd, cD;
    int burst, r;
    checks = 0;  errors = 0;  posCount = 0;  starve = 0;  ackSeen = 0;  modelAck = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    mem_rdata = 8'h00;
    reset = 1'b0;  cpu_wen = 0;  cpu_ren = 0;  cpu_addr = '0;  cpu_wdata = '0;
    dma_req = 0;  dma_we = 0;  dma_addr = '0;  dma_wdata = '0;
    @(negedge clk);

    $display("[TB] reset holds off all grants");
    repeat (3) applyStimulus(0, 1, 0, 16'h0020, 8'h11, 1, 1, 16'h0010, 8'h22, 0);
    idleCycle();

    $display("[TB] DMA write then read with idle CPU");
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 1, 16'h0010, 8'hA5, 0);
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0010, 8'h00, 0);
    idleCycle();

    $display("[TB] CPU wins a simultaneous access");
    applyStimulus(1, 1, 0, 16'h0020, 8'h5A, 1, 1, 16'h0030, 8'hC3, 0);
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 1, 16'h0030, 8'hC3, 0);
    applyStimulus(1, 0, 1, 16'h0020, 8'h0, 1, 0, 16'h0030, 8'h00, 0);
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0030, 8'h00, 0);
    idleCycle();

    $display("[TB] back-to-back DMA reads");
    for (int a = 0; a < 4; a++) begin
      shadow[a] = 8'(8'h60 + a);
      applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 1, 16'(a), 8'(8'h60 + a), 0);
    end
    for (int a = 0; a < 4; a++) applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'(a), 8'h0, 0);
    idleCycle();
    idleCycle();

    $display("[TB] continuous CPU traffic against a waiting DMA request");
    ackSeen = 0;
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 0, 1, 16'(i), 8'h0, 1, 1, 16'h0040, 8'h77, 0);
`ifdef AVR_ARB_STALL_EN
    checkOutput("starve_acks", 16'(ackSeen), 16'd1);
`else
    checkOutput("starve_acks", 16'(ackSeen), 16'd0);
`endif
    idleCycle();

    $display("[TB] reset right after an acked DMA read");
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0010, 8'h0, 1);
    applyStimulus(0, 1, 0, 16'h0020, 8'h99, 1, 1, 16'h0010, 8'h99, 0);
    applyStimulus(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0010, 8'h0, 0);
    idleCycle();

    $display("[TB] randomized traffic");
    pending = 0;  pWe = 0;  pAddr = '0;  pWd = '0;  burst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(6, 14);
      r = (burst > 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      if (burst > 0) burst--;
      cW = (r == 0);
      cR = (r == 1);
      cA = 16'($urandom) & 16'hFF0F;
      cD = 8'($urandom);
      if (!pending && $urandom_range(0, 9) < 6) begin
        pending = 1;
        pWe = 1'($urandom);
        pAddr = 16'($urandom) & 16'hFF0F;
        pWd = 8'($urandom);
      end
      applyStimulus(1, cW, cR, cA, cD, pending, pWe, pAddr, pWd, 0);
      if (modelAck) pending = 0;
    end
    idleCycle();
    idleCycle();

    checkOutput("queues_drained", 16'(rdQ.size() + cpuQ.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
